// File: rtl/simd_pkg.sv
// Opcodes, lane geometry and the radix-256 partial-product helper for the SIMD execution unit.
package simd_pkg;
  localparam int LANES  = 4;
  localparam int LANE_W = 32;

  typedef logic [2:0]        opcode_t;
  typedef logic [LANE_W-1:0] lane_t;

  localparam opcode_t OP_ADD  = 3'b000;
  localparam opcode_t OP_SUB  = 3'b001;
  localparam opcode_t OP_AND  = 3'b010;
  localparam opcode_t OP_OR   = 3'b011;
  localparam opcode_t OP_XOR  = 3'b100;
  localparam opcode_t OP_MUL  = 3'b101;
  localparam opcode_t OP_MAX  = 3'b110;
  localparam opcode_t OP_PASS = 3'b111;

  // a times byte idx of b, already shifted into its place in the 64-bit product.
  function automatic logic [2*LANE_W-1:0] mul_partial(input lane_t a, input lane_t b,
                                                      input logic [1:0] idx);
    logic [7:0]          digit;
    logic [2*LANE_W-1:0] pp;
    digit = b[{idx, 3'b000} +: 8];
    pp    = {{LANE_W{1'b0}}, a} * {{(2*LANE_W-8){1'b0}}, digit};
    return pp << {idx, 3'b000};
  endfunction
endpackage

// File: rtl/simd_if.sv
// Operand/control/result bundle of the SIMD unit; master drives operands, slave returns results.
interface simd_if;
  import simd_pkg::*;

  logic                    pad_valid_data;
  logic                    pad_valid_instruction;
  opcode_t                 pad_instruction;
  logic [5:0]              pad_data_size;
  logic [LANES*LANE_W-1:0] pad_mc_data_in_opa;
  logic [LANES*LANE_W-1:0] pad_mc_data_in_opb;
  lane_t                   pad_out_procc0;
  lane_t                   pad_out_procc1;
  lane_t                   pad_out_procc2;
  lane_t                   pad_out_procc3;
  lane_t                   pad_out_extra_procc0;
  lane_t                   pad_out_extra_procc1;
  lane_t                   pad_out_extra_procc2;
  lane_t                   pad_out_extra_procc3;

  modport master (
    output pad_valid_data, pad_valid_instruction, pad_instruction, pad_data_size,
           pad_mc_data_in_opa, pad_mc_data_in_opb,
    input  pad_out_procc0, pad_out_procc1, pad_out_procc2, pad_out_procc3,
           pad_out_extra_procc0, pad_out_extra_procc1, pad_out_extra_procc2, pad_out_extra_procc3
  );

  modport slave (
    input  pad_valid_data, pad_valid_instruction, pad_instruction, pad_data_size,
           pad_mc_data_in_opa, pad_mc_data_in_opb,
    output pad_out_procc0, pad_out_procc1, pad_out_procc2, pad_out_procc3,
           pad_out_extra_procc0, pad_out_extra_procc1, pad_out_extra_procc2, pad_out_extra_procc3
  );
endinterface

// File: rtl/simd_lane.sv
// One 32-bit lane: operand capture on the beat edge, ALU plus serial radix-256 multiplier,
// result registers loaded one clk later (or shifted as scan cells); no backpressure.
module simd_lane
  import simd_pkg::*;
(
  input  logic    clk,
  input  logic    clk_2,
  input  logic    reset,
  input  logic    beat,
  input  opcode_t op,
  input  lane_t   a,
  input  lane_t   b,
  input  logic    scan_en,
  input  logic    scan_in_a,
  input  logic    scan_in_b,
  output lane_t   out_procc,
  output lane_t   out_extra
);
  lane_t               a_q;
  lane_t               b_q;
  opcode_t             op_q;
  logic                pend;
  logic                mul_tag;
  logic                mul_seen;
  logic                mul_busy;
  logic [1:0]          mul_step;
  logic [2*LANE_W-1:0] mul_acc;
  logic [LANE_W:0]     sum;
  logic [LANE_W:0]     diff;
  lane_t               res_p;
  lane_t               res_x;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_PASS;
      pend    <= 1'b0;
      mul_tag <= 1'b0;
    end else begin
      pend <= beat;
      if (beat) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op;
        if (op == OP_MUL) mul_tag <= ~mul_tag;
      end
    end
  end

  // Falling clk_2 edges fit four steps strictly between two clk edges; a flipped
  // tag marks operands freshly captured on the last clk edge.
  always_ff @(negedge clk_2 or posedge reset) begin
    if (reset) begin
      mul_seen <= 1'b0;
      mul_busy <= 1'b0;
      mul_step <= 2'd0;
      mul_acc  <= '0;
    end else if (mul_tag != mul_seen) begin
      mul_seen <= mul_tag;
      mul_acc  <= mul_partial(a_q, b_q, 2'd0);
      mul_step <= 2'd1;
      mul_busy <= 1'b1;
    end else if (mul_busy) begin
      mul_acc  <= mul_acc + mul_partial(a_q, b_q, mul_step);
      mul_step <= mul_step + 2'd1;
      mul_busy <= (mul_step != 2'd3);
    end
  end

  always_comb begin
    sum   = {1'b0, a_q} + {1'b0, b_q};
    diff  = {1'b0, a_q} - {1'b0, b_q};
    res_p = '0;
    res_x = '0;
    case (op_q)
      OP_ADD: begin res_p = sum[LANE_W-1:0];  res_x = {{(LANE_W-1){1'b0}}, sum[LANE_W]};  end
      OP_SUB: begin res_p = diff[LANE_W-1:0]; res_x = {{(LANE_W-1){1'b0}}, diff[LANE_W]}; end
      OP_AND: res_p = a_q & b_q;
      OP_OR:  res_p = a_q | b_q;
      OP_XOR: res_p = a_q ^ b_q;
      OP_MUL: begin res_p = mul_acc[LANE_W-1:0]; res_x = mul_acc[2*LANE_W-1:LANE_W]; end
      OP_MAX: begin
        res_p = (a_q > b_q) ? a_q : b_q;
        res_x = (a_q > b_q) ? b_q : a_q;
      end
      default: begin res_p = a_q; res_x = b_q; end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_procc <= '0;
      out_extra <= '0;
    end else if (scan_en) begin
      out_procc <= {out_procc[LANE_W-2:0], scan_in_a};
      out_extra <= {out_extra[LANE_W-2:0], scan_in_b};
    end else if (pend) begin
      out_procc <= res_p;
      out_extra <= res_x;
    end
  end
endmodule

// File: rtl/simd_top_level.sv
// Four-lane SIMD execution unit top: opcode register, burst beat counter, lane split, scan mux.
// Results appear one clk after the accepted beat; no backpressure; DFT_SCAN_EN adds result-register scan chains.
module simd_top_level
  import simd_pkg::*;
(
  input  logic   pad_clk,
  input  logic   pad_reset,
  input  logic   pad_clk_2,
  simd_if.slave  bus,
  input  logic   pad_test_si1,
  input  logic   pad_test_si2,
  input  logic   pad_test_se,
  output logic   pad_test_so1
);
  opcode_t    op_q;
  opcode_t    op_eff;
  logic [5:0] beat_cnt;
  logic       beat;
  logic       scan_en;
  lane_t      opa_l [LANES];
  lane_t      opb_l [LANES];
  lane_t      out_l [LANES];
  lane_t      ext_l [LANES];
  logic       scan_a_l [LANES];
  logic       scan_b_l [LANES];

  // A newly loaded opcode already applies to a beat on the same edge.
  assign op_eff = bus.pad_valid_instruction ? bus.pad_instruction : op_q;
  assign beat   = bus.pad_valid_data &&
                  ((bus.pad_data_size == 6'd0) || (beat_cnt < bus.pad_data_size));

  always_ff @(posedge pad_clk or posedge pad_reset) begin
    if (pad_reset) begin
      op_q     <= OP_PASS;
      beat_cnt <= '0;
    end else begin
      if (bus.pad_valid_instruction) op_q <= bus.pad_instruction;
      if (!bus.pad_valid_data)                  beat_cnt <= '0;
      else if (beat && (beat_cnt != 6'h3f))     beat_cnt <= beat_cnt + 6'd1;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign opa_l[k] = bus.pad_mc_data_in_opa[k*LANE_W +: LANE_W];
    assign opb_l[k] = bus.pad_mc_data_in_opb[k*LANE_W +: LANE_W];

    simd_lane u_lane (
      .clk       (pad_clk),
      .clk_2     (pad_clk_2),
      .reset     (pad_reset),
      .beat      (beat),
      .op        (op_eff),
      .a         (opa_l[k]),
      .b         (opb_l[k]),
      .scan_en   (scan_en),
      .scan_in_a (scan_a_l[k]),
      .scan_in_b (scan_b_l[k]),
      .out_procc (out_l[k]),
      .out_extra (ext_l[k])
    );
  end

`ifdef DFT_SCAN_EN
  // Chains run lane 0 LSB -> lane 3 MSB; each lane feeds the next from its top bit.
  always_comb begin
    scan_en     = pad_test_se;
    scan_a_l[0] = pad_test_si1;
    scan_b_l[0] = pad_test_si2;
    for (int k = 1; k < LANES; k++) begin
      scan_a_l[k] = out_l[k-1][LANE_W-1];
      scan_b_l[k] = ext_l[k-1][LANE_W-1];
    end
  end
  assign pad_test_so1 = out_l[LANES-1][LANE_W-1] ^ ext_l[LANES-1][LANE_W-1];
`else
  logic unused_scan;
  always_comb begin
    scan_en = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      scan_a_l[k] = 1'b0;
      scan_b_l[k] = 1'b0;
    end
  end
  assign unused_scan  = pad_test_si1 ^ pad_test_si2 ^ pad_test_se;
  assign pad_test_so1 = 1'b0;
`endif

  assign bus.pad_out_procc0       = out_l[0];
  assign bus.pad_out_procc1       = out_l[1];
  assign bus.pad_out_procc2       = out_l[2];
  assign bus.pad_out_procc3       = out_l[3];
  assign bus.pad_out_extra_procc0 = ext_l[0];
  assign bus.pad_out_extra_procc1 = ext_l[1];
  assign bus.pad_out_extra_procc2 = ext_l[2];
  assign bus.pad_out_extra_procc3 = ext_l[3];
endmodule

// File: tb/tb_simd_top_level.sv
// Directed and random stimulus for simd_top_level against an arithmetic lane model.
module tb_simd_top_level;
  import simd_pkg::*;

  logic pad_clk, pad_clk_2, pad_reset;
  logic si1, si2, se, so1;
  int   checks = 0;
  int   failures = 0;

  logic [31:0]  exp_out [4];
  logic [31:0]  exp_ext [4];
  logic [31:0]  o [4];
  logic [31:0]  x [4];
  logic [2:0]   m_op;
  logic [5:0]   m_cnt;
  logic         m_pend;
  logic [2:0]   p_op;
  logic [127:0] p_a, p_b;

  simd_if sif();

  simd_top_level dut (
    .pad_clk      (pad_clk),
    .pad_reset    (pad_reset),
    .pad_clk_2    (pad_clk_2),
    .bus          (sif),
    .pad_test_si1 (si1),
    .pad_test_si2 (si2),
    .pad_test_se  (se),
    .pad_test_so1 (so1)
  );

  initial begin pad_clk = 1'b0;   forever #20 pad_clk   = ~pad_clk;   end
  initial begin pad_clk_2 = 1'b1; forever #5  pad_clk_2 = ~pad_clk_2; end

  assign o[0] = sif.pad_out_procc0;       assign x[0] = sif.pad_out_extra_procc0;
  assign o[1] = sif.pad_out_procc1;       assign x[1] = sif.pad_out_extra_procc1;
  assign o[2] = sif.pad_out_procc2;       assign x[2] = sif.pad_out_extra_procc2;
  assign o[3] = sif.pad_out_procc3;       assign x[3] = sif.pad_out_extra_procc3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_out%0d", tag, k), o[k], exp_out[k]);
      chk($sformatf("%s_ext%0d", tag, k), x[k], exp_ext[k]);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin exp_out[k] = '0; exp_ext[k] = '0; end
    m_op = 3'b111; m_cnt = '0; m_pend = 1'b0;
  endfunction

  // Lane results straight from the opcode definitions, using 64-bit arithmetic.
  function automatic void model_apply(input logic [2:0] op, input logic [127:0] a,
                                      input logic [127:0] b);
    logic [63:0] la, lb, p;
    for (int k = 0; k < 4; k++) begin
      la = {32'd0, a[32*k +: 32]};
      lb = {32'd0, b[32*k +: 32]};
      case (op)
        3'd0: begin p = la + lb; exp_out[k] = p[31:0]; exp_ext[k] = {31'd0, p[32]}; end
        3'd1: begin p = la - lb; exp_out[k] = p[31:0]; exp_ext[k] = (la < lb) ? 32'd1 : 32'd0; end
        3'd2: begin p = la & lb; exp_out[k] = p[31:0]; exp_ext[k] = '0; end
        3'd3: begin p = la | lb; exp_out[k] = p[31:0]; exp_ext[k] = '0; end
        3'd4: begin p = la ^ lb; exp_out[k] = p[31:0]; exp_ext[k] = '0; end
        3'd5: begin p = la * lb; exp_out[k] = p[31:0]; exp_ext[k] = p[63:32]; end
        3'd6: begin
          p = (la > lb) ? la : lb; exp_out[k] = p[31:0];
          p = (la > lb) ? lb : la; exp_ext[k] = p[31:0];
        end
        default: begin exp_out[k] = la[31:0]; exp_ext[k] = lb[31:0]; end
      endcase
    end
  endfunction

  // One clk edge: apply last edge's accepted beat, then record this edge's beat.
  task automatic tick();
    logic       take;
    logic [2:0] eff;
    eff  = sif.pad_valid_instruction ? sif.pad_instruction : m_op;
    take = sif.pad_valid_data && (sif.pad_data_size == 6'd0 || m_cnt < sif.pad_data_size);
    @(posedge pad_clk); #1;
    if (m_pend) model_apply(p_op, p_a, p_b);
    m_pend = take; p_op = eff; p_a = sif.pad_mc_data_in_opa; p_b = sif.pad_mc_data_in_opb;
    if (sif.pad_valid_instruction) m_op = sif.pad_instruction;
    if (!sif.pad_valid_data) m_cnt = '0;
    else if (take && m_cnt != 6'h3f) m_cnt = m_cnt + 6'd1;
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'hffff_ffff;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [127:0] rnd_bus();
    return {rnd_word(), rnd_word(), rnd_word(), rnd_word()};
  endfunction

  initial begin
    logic [127:0] cha, chb;
    sif.pad_valid_data = 1'b0; sif.pad_valid_instruction = 1'b0;
    sif.pad_instruction = 3'd0; sif.pad_data_size = 6'd0;
    sif.pad_mc_data_in_opa = '0; sif.pad_mc_data_in_opb = '0;
    si1 = 1'b0; si2 = 1'b0; se = 1'b0;
    pad_reset = 1'b1;
    model_reset();
    #5;
    check_all("reset");
    chk("reset_so1", {31'd0, so1}, 32'd0);
    #25 pad_reset = 1'b0;

    // Opcode register comes out of reset as PASS.
    sif.pad_valid_data = 1'b1;
    sif.pad_mc_data_in_opa = rnd_bus(); sif.pad_mc_data_in_opb = rnd_bus();
    tick();
    sif.pad_valid_data = 1'b0;
    tick();
    check_all("pass_default");
    chk("pass_lit", o[2], sif.pad_mc_data_in_opa[95:64]);

    // Back-to-back MUL beats.
    sif.pad_valid_instruction = 1'b1; sif.pad_instruction = OP_MUL; sif.pad_valid_data = 1'b1;
    sif.pad_mc_data_in_opa = 128'h11111111_22222222_55555555_66666666;
    sif.pad_mc_data_in_opb = 128'h11111111_22222222_33333333_44444444;
    tick();
    sif.pad_valid_instruction = 1'b0;
    sif.pad_mc_data_in_opa = {4{32'hffff_ffff}}; sif.pad_mc_data_in_opb = {4{32'h1}};
    tick();
    check_all("mul_vec");
    chk("mul_l3_out", o[3], 32'h8765_4321); chk("mul_l3_ext", x[3], 32'h0123_4567);
    chk("mul_l2_out", o[2], 32'h1D95_0C84); chk("mul_l2_ext", x[2], 32'h048D_159E);
    sif.pad_mc_data_in_opa = {4{32'h1}}; sif.pad_mc_data_in_opb = {4{32'h9999_9999}};
    tick();
    check_all("mul_ff");
    chk("mul_ff_out", o[0], 32'hffff_ffff); chk("mul_ff_ext", x[0], 32'h0);
    sif.pad_valid_data = 1'b0;
    tick();
    check_all("mul_99");
    chk("mul_99_out", o[1], 32'h9999_9999); chk("mul_99_ext", x[1], 32'h0);

    // ADD carry then SUB borrow, opcode switching on the beat edge.
    sif.pad_valid_instruction = 1'b1; sif.pad_instruction = OP_ADD; sif.pad_valid_data = 1'b1;
    sif.pad_mc_data_in_opa = {4{32'hffff_ffff}}; sif.pad_mc_data_in_opb = {4{32'h1}};
    tick();
    sif.pad_instruction = OP_SUB;
    sif.pad_mc_data_in_opa = '0;
    tick();
    check_all("add");
    chk("add_out", o[2], 32'h0); chk("add_carry", x[2], 32'h1);
    sif.pad_valid_instruction = 1'b0; sif.pad_valid_data = 1'b0;
    tick();
    check_all("sub");
    chk("sub_out", o[3], 32'hffff_ffff); chk("sub_borrow", x[3], 32'h1);

    // Burst length 2: beats 2 and 3 ignored until valid_data drops.
    sif.pad_valid_instruction = 1'b1; sif.pad_instruction = OP_PASS;
    sif.pad_data_size = 6'd2; sif.pad_valid_data = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      sif.pad_mc_data_in_opa = {4{32'(i)}}; sif.pad_mc_data_in_opb = {4{~32'(i)}};
      tick();
      sif.pad_valid_instruction = 1'b0;
      check_all("burst");
    end
    sif.pad_valid_data = 1'b0;
    tick();
    check_all("burst_end");
    chk("burst_last_out", o[0], 32'd2); chk("burst_last_ext", x[0], ~32'd2);
    sif.pad_valid_data = 1'b1; sif.pad_mc_data_in_opa = {4{32'h77}};
    tick();
    sif.pad_valid_data = 1'b0;
    tick();
    chk("burst_resume", o[1], 32'h77);
    sif.pad_data_size = 6'd0;

    // Random opcodes, bursts and operands.
    for (int n = 0; n < 80; n++) begin
      sif.pad_valid_instruction = ($urandom_range(0, 3) == 0);
      sif.pad_instruction       = 3'($urandom_range(0, 7));
      sif.pad_valid_data        = ($urandom_range(0, 4) != 0);
      sif.pad_data_size         = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 5)) : 6'd0;
      sif.pad_mc_data_in_opa    = rnd_bus();
      sif.pad_mc_data_in_opb    = rnd_bus();
      tick();
      check_all("rnd");
    end
    sif.pad_data_size = 6'd0;

    // Reset in the middle of a MUL burst.
    sif.pad_valid_instruction = 1'b1; sif.pad_instruction = OP_MUL; sif.pad_valid_data = 1'b1;
    sif.pad_mc_data_in_opa = rnd_bus(); sif.pad_mc_data_in_opb = rnd_bus();
    tick();
    sif.pad_valid_instruction = 1'b0;
    sif.pad_mc_data_in_opa = rnd_bus(); sif.pad_mc_data_in_opb = rnd_bus();
    tick();
    #8 pad_reset = 1'b1;
    #1;
    model_reset();
    check_all("reset_mid");
    @(posedge pad_clk); #1;
    check_all("reset_hold");
    #10 pad_reset = 1'b0;
    sif.pad_valid_instruction = 1'b1; sif.pad_instruction = OP_MUL; sif.pad_valid_data = 1'b1;
    sif.pad_mc_data_in_opa = {$urandom(), $urandom(), $urandom(), $urandom()};
    sif.pad_mc_data_in_opb = {$urandom(), $urandom(), $urandom(), $urandom()};
    tick();
    sif.pad_valid_instruction = 1'b0; sif.pad_valid_data = 1'b0;
    tick();
    check_all("mul_after_reset");

`ifdef DFT_SCAN_EN
    tick();
    cha = {exp_out[3], exp_out[2], exp_out[1], exp_out[0]};
    chb = {exp_ext[3], exp_ext[2], exp_ext[1], exp_ext[0]};
    chk("scan_so1_init", {31'd0, so1}, {31'd0, cha[127] ^ chb[127]});
    se = 1'b1;
    for (int i = 0; i < 128; i++) begin
      si1 = 1'($urandom()); si2 = 1'($urandom());
      @(posedge pad_clk); #1;
      cha = {cha[126:0], si1};
      chb = {chb[126:0], si2};
      chk("scan_so1", {31'd0, so1}, {31'd0, cha[127] ^ chb[127]});
    end
    se = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_out[k] = cha[32*k +: 32];
      exp_ext[k] = chb[32*k +: 32];
    end
    check_all("after_scan");
`else
    // Scan pins have no effect without the scan build.
    se = 1'b1; si1 = 1'b1; si2 = 1'b1;
    sif.pad_valid_instruction = 1'b1; sif.pad_instruction = OP_XOR; sif.pad_valid_data = 1'b1;
    sif.pad_mc_data_in_opa = rnd_bus(); sif.pad_mc_data_in_opb = rnd_bus();
    tick();
    sif.pad_valid_instruction = 1'b0; sif.pad_valid_data = 1'b0;
    tick();
    check_all("se_ignored");
    chk("so1_tied", {31'd0, so1}, 32'd0);
    se = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
